// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// ============================================================================
// mem_access_stage
// ----------------------------------------------------------------------------
// Memory-access pipeline stage sitting between Execute and Write-back.
//
// Accepts one Execute result at a time while IDLE and either forwards it
// straight to write-back (non-memory op), performs a load, a word store, or a
// byte/half store implemented as a read-modify-write of the containing word.
// The memory is word-wide and big-endian (byte offset 0 = bits 31:24), and
// every access is issued as an aligned word. While an access is in flight the
// stage raises stall so Execute holds its result.
//
// Parameters
//   BUSY_TIMEOUT   consecutive mem_busy cycles tolerated in a request state
//                  before the access is abandoned with an err pulse.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   ex_valid       Execute result present (sampled only while IDLE)
//   ex_result      ALU result / effective address
//   ex_store_data  store data (rt)
//   ex_mem_read    op is a load
//   ex_mem_write   op is a store
//   ex_size        00 byte, 01 half, 10 word
//   ex_unsigned    zero-extend loaded byte/half instead of sign-extending
//   ex_rd          destination register
//   mem_addr       word-aligned memory address
//   mem_data_out   write data to memory
//   mem_data_in    read data from memory (valid the cycle after acceptance)
//   mem_acc_size   always 00 (single word)
//   mem_wren       write enable
//   mem_enable     request strobe; accepted when mem_busy is low
//   mem_busy       memory cannot accept the request this cycle
//   stall          stage is busy, hold the upstream result
//   wb_valid       one-cycle write-back pulse
//   wb_rd          write-back destination register
//   wb_data        write-back data
//   err            one-cycle pulse on misaligned op or busy timeout
// ============================================================================
module mem_access_stage #(
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [4:0]  ex_rd,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic [1:0]  mem_acc_size,
    output logic        mem_wren,
    output logic        mem_enable,
    input  logic        mem_busy,

    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_REQ   = 3'd1;
    localparam logic [2:0] LD_DATA  = 3'd2;
    localparam logic [2:0] ST_REQ   = 3'd3;
    localparam logic [2:0] RMW_REQ  = 3'd4;
    localparam logic [2:0] RMW_DATA = 3'd5;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [7:0] TIMEOUT_CNT = 8'(BUSY_TIMEOUT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic [1:0] size_q;
    logic       unsigned_q;
    logic [1:0] offset_q;

    // ------------------------------------------------------------------------
    // Decode of the incoming Execute op
    // ------------------------------------------------------------------------
    logic [1:0] ex_offset;
    logic       ex_is_mem;
    logic       ex_misaligned;

    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        ex_offset     = ex_result[1:0];
        ex_is_mem     = ex_mem_read | ex_mem_write;
        ex_misaligned = 1'b0;
        if (ex_mem_read && ex_mem_write) begin
            // Conflicting request: reject rather than guess which was meant.
            ex_misaligned = 1'b1;
        end else if (ex_is_mem) begin
            case (ex_size)
                SIZE_BYTE: ex_misaligned = 1'b0;
                SIZE_HALF: ex_misaligned = ex_offset[0];
                SIZE_WORD: ex_misaligned = (ex_offset != 2'b00);
                default:   ex_misaligned = 1'b1;  // reserved size encoding
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Load extraction: pick the addressed byte/half out of the returned word
    // (big-endian lanes) and extend it.
    // ------------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;

    always_comb begin
        ld_byte = 8'h00;
        case (offset_q)
            2'd0: ld_byte = mem_data_in[31:24];
            2'd1: ld_byte = mem_data_in[23:16];
            2'd2: ld_byte = mem_data_in[15:8];
            2'd3: ld_byte = mem_data_in[7:0];
            default: ld_byte = 8'h00;
        endcase

        ld_half = offset_q[1] ? mem_data_in[15:0] : mem_data_in[31:16];

        load_value = mem_data_in;
        case (size_q)
            SIZE_BYTE: load_value = unsigned_q ? {24'h000000, ld_byte}
                                               : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_value = unsigned_q ? {16'h0000, ld_half}
                                               : {{16{ld_half[15]}}, ld_half};
            default:   load_value = mem_data_in;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store merge for sub-word stores. mem_data_out still holds the original
    // ex_store_data from sampling time (it is only overwritten here), so its
    // low byte/half is the value to insert into the word just read.
    // ------------------------------------------------------------------------
    logic [31:0] merged_word;

    always_comb begin
        merged_word = mem_data_in;
        if (size_q == SIZE_BYTE) begin
            case (offset_q)
                2'd0: merged_word[31:24] = mem_data_out[7:0];
                2'd1: merged_word[23:16] = mem_data_out[7:0];
                2'd2: merged_word[15:8]  = mem_data_out[7:0];
                2'd3: merged_word[7:0]   = mem_data_out[7:0];
                default: merged_word = mem_data_in;
            endcase
        end else if (offset_q[1]) begin
            merged_word[15:0]  = mem_data_out[15:0];
        end else begin
            merged_word[31:16] = mem_data_out[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side strobes are pure functions of the state, so they are held
    // for as long as a request state is held under mem_busy, and they drop in
    // the same edge that leaves the request state (acceptance, timeout, reset).
    // ------------------------------------------------------------------------
    logic req_state;
    logic busy_expired;

    assign req_state    = (state == LD_REQ) || (state == ST_REQ) || (state == RMW_REQ);
    assign mem_enable   = req_state;
    assign mem_wren     = (state == ST_REQ);
    assign mem_acc_size = 2'b00;
    assign stall        = (state != IDLE);

    // wait_cnt counts busy cycles already spent; this one is the last allowed.
    assign busy_expired = mem_busy && ((wait_cnt + 8'd1) == TIMEOUT_CNT);

    // ------------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge, independent of order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            offset_q     <= 2'b00;
            mem_addr     <= 32'h0000_0000;
            mem_data_out <= 32'h0000_0000;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0000_0000;
            err          <= 1'b0;
        end else begin
            // Both are single-cycle pulses unless re-asserted below.
            wb_valid <= 1'b0;
            err      <= 1'b0;

            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        wb_rd      <= ex_rd;
                        size_q     <= ex_size;
                        unsigned_q <= ex_unsigned;
                        offset_q   <= ex_result[1:0];

                        if (!ex_is_mem) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ex_result;
                        end else if (ex_misaligned) begin
                            err <= 1'b1;
                        end else begin
                            mem_addr     <= {ex_result[31:2], 2'b00};
                            mem_data_out <= ex_store_data;
                            wait_cnt     <= 8'd0;
                            if (ex_mem_read) begin
                                state <= LD_REQ;
                            end else if (ex_size == SIZE_WORD) begin
                                state <= ST_REQ;
                            end else begin
                                state <= RMW_REQ;
                            end
                        end
                    end
                end

                LD_REQ, ST_REQ, RMW_REQ: begin
                    if (mem_busy) begin
                        if (busy_expired) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        // Accepted this cycle.
                        case (state)
                            LD_REQ:  state <= LD_DATA;
                            RMW_REQ: state <= RMW_DATA;
                            default: state <= IDLE;     // ST_REQ: write done
                        endcase
                    end
                end

                LD_DATA: begin
                    wb_data  <= load_value;
                    wb_valid <= 1'b1;
                    state    <= IDLE;
                end

                RMW_DATA: begin
                    mem_data_out <= merged_word;
                    wait_cnt     <= 8'd0;
                    state        <= ST_REQ;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access_stage. Stimulus pushes expected
// write-backs, memory accesses and error pulses into queues; monitor
// processes pop and compare whenever the DUT presents the matching output.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_size = 2'b10;
    logic        ex_unsigned = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in = 32'hDEAD_BEEF;
    logic [1:0]  mem_acc_size;
    logic        mem_wren;
    logic        mem_enable;
    logic        mem_busy = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    always #5 clock = ~clock;

    mem_access_stage #(.BUSY_TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_result    (ex_result),
        .ex_store_data(ex_store_data),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_rd        (ex_rd),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_acc_size (mem_acc_size),
        .mem_wren     (mem_wren),
        .mem_enable   (mem_enable),
        .mem_busy     (mem_busy),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err)
    );

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        string       name;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    wb_exp_t  exp_wb[$];
    mem_exp_t exp_mem[$];
    int       err_expected = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model state (single word is enough for these vectors)
    logic [31:0] mem_word   = '0;
    int          busy_left  = 0;
    logic        busy_stuck = 1'b0;
    logic        rd_pending = 1'b0;
    int          accepts    = 0;
    logic        hold_prev  = 1'b0;
    logic        hold_wren  = 1'b0;
    logic [31:0] hold_addr  = '0;
    logic [31:0] hold_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input string name, input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.name = name; e.rd = rd; e.data = data;
        exp_wb.push_back(e);
    endtask

    task automatic expect_mem(input string name, input logic wren, input logic [31:0] addr,
                              input logic [31:0] data);
        mem_exp_t e;
        e.name = name; e.wren = wren; e.addr = addr; e.data = data;
        exp_mem.push_back(e);
    endtask

    // Leaves the caller at a falling edge with the stage IDLE.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (stall === 1'b0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: stall still %b after 100 cycles, required 0", stall);
    endtask

    // Presents one op for exactly one sampling edge; returns just after it.
    task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] size,
                         input logic uns, input logic [31:0] res, input logic [31:0] sdata,
                         input logic [4:0] rd);
        wait_idle();
        ex_valid      = 1'b1;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_size       = size;
        ex_unsigned   = uns;
        ex_result     = res;
        ex_store_data = sdata;
        ex_rd         = rd;
        @(posedge clock);
        #1;
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Memory model + access monitor
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        mem_exp_t m;
        // Read data appears in the cycle after acceptance only.
        mem_data_in = rd_pending ? mem_word : 32'hDEAD_BEEF;
        rd_pending  = 1'b0;

        if (hold_prev && !err && !reset) begin
            check("hold_enable", 32'(mem_enable), 32'd1);
            check("hold_wren", 32'(mem_wren), 32'(hold_wren));
            check("hold_addr", mem_addr, hold_addr);
            check("hold_data", mem_data_out, hold_data);
        end

        if (mem_enable === 1'b1 && (busy_stuck || busy_left > 0)) begin
            mem_busy = 1'b1;
            if (busy_left > 0) busy_left--;
        end else begin
            mem_busy = 1'b0;
        end

        hold_prev = (mem_enable === 1'b1) && mem_busy;
        hold_wren = mem_wren;
        hold_addr = mem_addr;
        hold_data = mem_data_out;

        if (mem_enable === 1'b1 && !mem_busy && !reset) begin
            accepts++;
            check("acc_size", 32'(mem_acc_size), 32'd0);
            if (exp_mem.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_mem_access: got wren=%0b addr=0x%08h, required no access",
                         mem_wren, mem_addr);
            end else begin
                m = exp_mem.pop_front();
                check({m.name, "_wren"}, 32'(mem_wren), 32'(m.wren));
                check({m.name, "_addr"}, mem_addr, m.addr);
                if (m.wren) check({m.name, "_wdata"}, mem_data_out, m.data);
            end
            if (mem_wren) mem_word = mem_data_out;
            else          rd_pending = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Write-back / error monitor
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        wb_exp_t w;
        if (wb_valid === 1'b1) begin
            if (exp_wb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%08h, required no write-back",
                         wb_rd, wb_data);
            end else begin
                w = exp_wb.pop_front();
                check({w.name, "_rd"}, 32'(wb_rd), 32'(w.rd));
                check({w.name, "_data"}, wb_data, w.data);
            end
        end
        if (err === 1'b1) begin
            if (err_expected == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_err: got err=1, required 0");
            end else begin
                err_expected--;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        int a0;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_enable", 32'(mem_enable), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_data_out, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        reset = 1'b0;

        // lw: stall for two cycles, write-back at T+3
        mem_word = 32'h8001_2345;
        expect_mem("lw", 1'b0, 32'h8002_0004, 32'h0);
        expect_wb("lw", 5'd3, 32'h8001_2345);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8002_0004, 32'h0, 5'd3);
        @(negedge clock);
        check("lw_stall_t1", 32'(stall), 32'd1);
        @(negedge clock);
        check("lw_stall_t2", 32'(stall), 32'd1);
        @(negedge clock);
        check("lw_wb_valid_t3", 32'(wb_valid), 32'd1);
        check("lw_stall_t3", 32'(stall), 32'd0);

        // Sub-word loads
        mem_word = 32'h12F4_5678;
        expect_mem("lb", 1'b0, 32'h8002_0004, 32'h0);
        expect_wb("lb", 5'd4, 32'hFFFF_FFF4);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h8002_0005, 32'h0, 5'd4);
        wait_idle();
        expect_mem("lbu", 1'b0, 32'h8002_0004, 32'h0);
        expect_wb("lbu", 5'd6, 32'h0000_00F4);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h8002_0005, 32'h0, 5'd6);
        wait_idle();
        mem_word = 32'h1234_8001;
        expect_mem("lh", 1'b0, 32'h8002_0004, 32'h0);
        expect_wb("lh", 5'd7, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h8002_0006, 32'h0, 5'd7);
        wait_idle();
        expect_mem("lhu", 1'b0, 32'h8002_0004, 32'h0);
        expect_wb("lhu", 5'd8, 32'h0000_1234);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h8002_0004, 32'h0, 5'd8);
        wait_idle();

        // Sub-word stores: read then merged write, no write-back
        mem_word = 32'h1122_3344;
        expect_mem("sb_rd", 1'b0, 32'h8002_0000, 32'h0);
        expect_mem("sb_wr", 1'b1, 32'h8002_0000, 32'h1122_AB44);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h8002_0002, 32'h1234_56AB, 5'd0);
        wait_idle();
        expect_mem("sh_rd", 1'b0, 32'h8002_0000, 32'h0);
        expect_mem("sh_wr", 1'b1, 32'h8002_0000, 32'hBEEF_AB44);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h8002_0000, 32'h1234_BEEF, 5'd0);
        wait_idle();

        // sw held under busy for 3 cycles
        busy_left = 3;
        expect_mem("sw_busy", 1'b1, 32'h8002_0010, 32'hCAFE_F00D);
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8002_0010, 32'hCAFE_F00D, 5'd0);
        wait_idle();

        // sw with busy stuck: abort after 4 busy cycles
        busy_stuck = 1'b1;
        err_expected++;
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8002_0020, 32'h0102_0304, 5'd0);
        repeat (4) @(negedge clock);
        check("to_enable_waiting", 32'(mem_enable), 32'd1);
        @(negedge clock);
        check("to_err", 32'(err), 32'd1);
        check("to_enable_off", 32'(mem_enable), 32'd0);
        check("to_stall", 32'(stall), 32'd0);
        busy_stuck = 1'b0;

        // Misaligned lw: err, no access, err is a single pulse
        a0 = accepts;
        err_expected++;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8002_0002, 32'h0, 5'd9);
        @(negedge clock);
        check("mis_lw_err", 32'(err), 32'd1);
        check("mis_lw_stall", 32'(stall), 32'd0);
        @(negedge clock);
        check("mis_lw_err_pulse", 32'(err), 32'd0);
        check("mis_lw_no_access", 32'(accepts), 32'(a0));

        // Misaligned half store and read+write conflict
        err_expected++;
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h8002_0001, 32'h0, 5'd0);
        @(negedge clock);
        check("mis_sh_err", 32'(err), 32'd1);
        err_expected++;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h8002_0008, 32'h0, 5'd12);
        @(negedge clock);
        check("rw_conflict_err", 32'(err), 32'd1);

        // Non-memory op
        expect_wb("add", 5'd5, 32'h0000_0007);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0007, 32'h0, 5'd5);
        @(negedge clock);
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_stall", 32'(stall), 32'd0);

        // No ex_valid: nothing happens
        a0 = accepts;
        repeat (5) @(negedge clock);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_no_access", 32'(accepts), 32'(a0));

        // Reset while in LD_DATA abandons the load
        mem_word = 32'h55AA_55AA;
        expect_mem("rst_ld", 1'b0, 32'h8002_0004, 32'h0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8002_0004, 32'h0, 5'd10);
        @(negedge clock);
        @(negedge clock);
        check("rst_ld_stall_before", 32'(stall), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ld_stall", 32'(stall), 32'd0);
        check("rst_ld_wb_valid", 32'(wb_valid), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Recovery after reset
        mem_word = 32'h0BAD_F00D;
        expect_mem("lw_after_rst", 1'b0, 32'h8002_0008, 32'h0);
        expect_wb("lw_after_rst", 5'd11, 32'h0BAD_F00D);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8002_0008, 32'h0, 5'd11);
        wait_idle();
        repeat (4) @(negedge clock);

        check("drain_wb", 32'(exp_wb.size()), 32'd0);
        check("drain_mem", 32'(exp_mem.size()), 32'd0);
        check("drain_err", 32'(err_expected), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 255: max consecutive cycles a memory request may wait on mem_busy before abort.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ex_valid in 1: an Execute result is presented; ex_result in 32: ALU result / effective address; ex_store_data in 32: rt value.
REQ-005 SHALL have ex_mem_read in 1, ex_mem_write in 1, ex_size in 2 (00 byte, 01 half, 10 word), ex_unsigned in 1, ex_rd in 5: destination register.
REQ-006 SHALL have memory-side ports mem_addr out 32, mem_data_out out 32 (to memory data_in), mem_data_in in 32 (memory data_out), mem_acc_size out 2, mem_wren out 1, mem_enable out 1, mem_busy in 1.
REQ-007 SHALL have outputs stall 1, wb_valid 1, wb_rd 5, wb_data 32, err 1 (misalign/timeout pulse).

Function
REQ-008 SHALL drive mem_acc_size = 00 (single word) for every access; sub-word handling is internal.
REQ-009 SHALL treat a memory request as accepted in a cycle where mem_enable=1 and mem_busy=0; read data is valid on mem_data_in the cycle after acceptance.
REQ-010 SHALL drive mem_addr = {ex_result[31:2], 00} (word aligned) for all accesses, with bytes big-endian: byte offset 0 = bits 31:24.
REQ-011 SHALL have states IDLE, LD_REQ, LD_DATA, ST_REQ, RMW_REQ, RMW_DATA; sample ex_* only in IDLE when ex_valid=1.
REQ-012 SHALL assert stall combinationally whenever state != IDLE.
REQ-013 Non-memory op (ex_mem_read=ex_mem_write=0): wb_valid=1, wb_data=ex_result, wb_rd=ex_rd in the next cycle; no memory activity.
REQ-014 Load: IDLE->LD_REQ (enable=1, wren=0) ->(accepted) LD_DATA -> IDLE; in LD_DATA capture mem_data_in, select byte/half by offset, zero-extend if ex_unsigned else sign-extend; wb_valid pulses the cycle after LD_DATA (load issued at T, no busy: wb_valid at T+3).
REQ-015 Word store: IDLE->ST_REQ (enable=1, wren=1, mem_data_out=store data) ->(accepted) IDLE; no wb_valid.
REQ-016 Byte/half store: IDLE->RMW_REQ (read) ->RMW_DATA (merge low byte/half of ex_store_data into captured word at offset) ->ST_REQ (write merged word) ->IDLE.
REQ-017 Misaligned (half with offset bit0=1; word with offset != 00): no memory access, no wb_valid; err pulses one cycle after sampling; stays IDLE.
REQ-018 ex_mem_read and ex_mem_write both 1 SHALL be treated as misaligned (err, no access).
REQ-019 In any *_REQ state, mem_enable, mem_addr, mem_wren, mem_data_out SHALL be held stable while mem_busy=1.
REQ-020 A 8-bit wait counter SHALL clear on entry to each *_REQ state and count busy cycles; on reaching BUSY_TIMEOUT: err pulse, enable/wren deassert, return IDLE, no wb_valid.
REQ-021 mem_enable and mem_wren SHALL be 0 in IDLE, LD_DATA, RMW_DATA; wb_valid and err are single-cycle pulses.
REQ-022 ex_valid=0 in IDLE SHALL produce no activity.

Reset
REQ-023 On reset: state IDLE; stall, wb_valid, err, mem_enable, mem_wren = 0; mem_addr, mem_data_out, wb_data = 0; wb_rd = 0; wait counter 0.
REQ-024 Reset mid-operation SHALL abandon the access in the same edge: no wb_valid, no write issued after reset.

Verification
REQ-025 lw, addr 0x80020004, memory word 0x8001_2345, busy=0 -> enable once with wren=0 at 0x80020004; wb_valid at T+3, wb_data 0x80012345; stall high T+1..T+2.
REQ-026 lb at 0x80020005, word 0x12F4_5678 -> wb_data 0xFFFF_FFF4; lbu same -> 0x0000_00F4; lh at 0x80020006 of 0x1234_8001 -> 0xFFFF_8001.
REQ-027 sb 0xAB at 0x80020002, word 0x1122_3344 -> one read, then write of 0x1122_AB44 to 0x80020000; no wb_valid.
REQ-028 sw with mem_busy high 3 cycles -> outputs stable 3 cycles, one accepted write; with BUSY_TIMEOUT=4 and busy stuck -> err pulse after 4 waits, IDLE, enable=0.
REQ-029 lw at 0x80020002 -> err pulse, mem_enable never asserted; add (rd=5, result 0x7) -> wb_valid next cycle, wb_rd=5, wb_data=0x7.
REQ-030 reset asserted in LD_DATA -> next cycle IDLE, stall=0, wb_valid never asserted.
